stepper_motion_ctrl: RTL

//  Sequences the shutter stepper. Accepts home/move commands decoded from the SPI frame and homes against the

---
 rtl/stepper_motion_ctrl_if.sv | 10 +
 rtl/stepper_motion_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/stepper_motion_ctrl_if.sv
// Command bus from the SPI frame decoder into the shutter stepper sequencer.
interface stepper_motion_ctrl_if #(parameter int POS_W = 8);
  logic             cmd_valid;
  logic [POS_W-1:0] cmd_target;
  logic             cmd_home;
  logic             cmd_ready;

  modport master (output cmd_valid, cmd_target, cmd_home, input cmd_ready);
  modport slave  (input cmd_valid, cmd_target, cmd_home, output cmd_ready);
endinterface

// File: rtl/stepper_motion_ctrl.sv
// Shutter stepper sequencer: homing against the limit switch, fixed-rate step/dir
// generation, absolute position tracking and idle motor-enable drop.
module stepper_motion_ctrl #(
  parameter int POS_W       = 8,
  parameter int MAX_POS     = 200,
  parameter int STEP_DIV    = 50000,
  parameter int STEP_HIGH   = 50,
  parameter int DIR_SETUP   = 100,
  parameter int HOLD_CYCLES = 50000000,
  parameter int HOME_MAX    = 400
) (
  input  logic                 clk50M,
  input  logic                 rst,
  input  logic                 limit_n,
  stepper_motion_ctrl_if.slave cmd,
  output logic                 step_pulse,
  output logic                 dir,
  output logic                 m_en,
  output logic [POS_W-1:0]     pos,
  output logic                 homed,
  output logic                 busy,
  output logic                 done,
  output logic                 fault
);

  localparam int PER_W = $clog2(STEP_DIV + 1);
  localparam int SET_W = $clog2(DIR_SETUP + 1);
  localparam int HLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int HCN_W = $clog2(HOME_MAX + 1);

  localparam logic [POS_W-1:0] MAXP     = POS_W'(MAX_POS);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(STEP_DIV - 1);
  localparam logic [PER_W-1:0] HI_LAST  = PER_W'(STEP_HIGH - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(DIR_SETUP - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYCLES - 1);
  localparam logic [HCN_W-1:0] HOME_LIM = HCN_W'(HOME_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_MOVE, S_HOMING, S_HOLD, S_FAULT
  } state_t;

  state_t           state;
  logic [1:0]       lim_sync;
  logic             homing;
  logic [POS_W-1:0] tgt;
  logic [SET_W-1:0] set_cnt;
  logic [PER_W-1:0] per_cnt;
  logic [HCN_W-1:0] home_cnt;
  logic [HLD_W-1:0] hold_cnt;

  logic             lim_act;
  logic             step_edge;
  logic [POS_W-1:0] tgt_c;

  assign lim_act = ~lim_sync[1];
  assign tgt_c   = (cmd.cmd_target > MAXP) ? MAXP : cmd.cmd_target;

  // A step decision is taken at the end of setup and at every period boundary.
  assign step_edge = ((state == S_SETUP) && (set_cnt == SET_LAST)) ||
                     (((state == S_MOVE) || (state == S_HOMING)) && (per_cnt == PER_LAST));

  assign busy          = (state == S_SETUP) || (state == S_MOVE) || (state == S_HOMING);
  assign cmd.cmd_ready = (state == S_IDLE) || (state == S_HOLD) || (state == S_FAULT);

  always_ff @(posedge clk50M) begin
    if (rst) begin
      lim_sync   <= 2'b11;
      state      <= S_IDLE;
      step_pulse <= 1'b0;
      dir        <= 1'b0;
      m_en       <= 1'b0;
      pos        <= '0;
      homed      <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      homing     <= 1'b0;
      tgt        <= '0;
      set_cnt    <= '0;
      per_cnt    <= '0;
      home_cnt   <= '0;
      hold_cnt   <= '0;
    end else begin
      lim_sync <= {lim_sync[0], limit_n};
      done     <= 1'b0;

      case (state)
        S_IDLE, S_HOLD, S_FAULT: begin
          if (state == S_HOLD) begin
            if (hold_cnt == HLD_LAST) begin
              m_en  <= 1'b0;
              state <= S_IDLE;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          if (cmd.cmd_home) begin
            fault    <= 1'b0;
            homed    <= 1'b0;
            dir      <= 1'b0;
            m_en     <= 1'b1;
            homing   <= 1'b1;
            set_cnt  <= '0;
            home_cnt <= '0;
            state    <= S_SETUP;
          end else if (cmd.cmd_valid && (state != S_FAULT)) begin
            if (!homed) begin
              fault <= 1'b1;
              state <= S_FAULT;
            end else if (tgt_c == pos) begin
              // Already there: acknowledge without touching state or the hold timer.
              done <= 1'b1;
            end else begin
              tgt     <= tgt_c;
              dir     <= (tgt_c > pos);
              m_en    <= 1'b1;
              homing  <= 1'b0;
              set_cnt <= '0;
              state   <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (set_cnt != SET_LAST) set_cnt <= set_cnt + 1'b1;
        end
        S_MOVE, S_HOMING: begin
          if (per_cnt != PER_LAST) begin
            per_cnt <= per_cnt + 1'b1;
            if (per_cnt == HI_LAST) step_pulse <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (step_edge) begin
        if (homing) begin
          if (lim_act) begin
            pos      <= '0;
            homed    <= 1'b1;
            done     <= 1'b1;
            hold_cnt <= '0;
            state    <= S_HOLD;
          end else if (home_cnt == HOME_LIM) begin
            fault <= 1'b1;
            m_en  <= 1'b0;
            state <= S_FAULT;
          end else begin
            step_pulse <= 1'b1;
            home_cnt   <= home_cnt + 1'b1;
            per_cnt    <= '0;
            state      <= S_HOMING;
          end
        end else begin
          if (pos == tgt) begin
            done     <= 1'b1;
            hold_cnt <= '0;
            state    <= S_HOLD;
          end else begin
            step_pulse <= 1'b1;
            pos        <= dir ? pos + 1'b1 : pos - 1'b1;
            per_cnt    <= '0;
            state      <= S_MOVE;
          end
        end
      end

      // Limit hit while still believing we are away from home: steps were lost.
      if ((state == S_MOVE) && lim_act && !dir && (pos != '0)) begin
        step_pulse <= 1'b0;
        pos        <= '0;
        homed      <= 1'b0;
        fault      <= 1'b1;
        m_en       <= 1'b0;
        done       <= 1'b0;
        state      <= S_FAULT;
      end
    end
  end

endmodule
